// File: rtl/zcd_pie_decoder.sv
// rtl/zcd_pie_decoder.sv - PIE symbol decoder for a zero-crossing pulse train (optional filter: ZCD_GLITCH_FILTER_EN)
module zcd_pie_decoder #(
  parameter int                 CNT_W      = 5,
  parameter int                 ZERO_MIN   = 3,
  parameter int                 ZERO_MAX   = 6,
  parameter int                 ONE_MIN    = 9,
  parameter int                 ONE_MAX    = 12,
  parameter int                 GAP_CYCLES = 2,
  parameter int                 SEQ_LEN    = 4,
  parameter logic [SEQ_LEN-1:0] SEQ        = 4'b0101
) (
  input  logic             sclk_3mhz,
  input  logic             reset_n,
  input  logic             zcd_pulse,
  input  logic             enable,
  output logic             sym_valid,
  output logic             sym_bit,
  output logic             sym_err,
  output logic [CNT_W-1:0] hi_width,
  output logic             seq_detected,
  output logic [7:0]       err_count
);

  localparam int LO_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int FILL_W = $clog2(SEQ_LEN + 1);

  localparam logic [CNT_W-1:0]  HI_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  Z_MIN    = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0]  Z_MAX    = CNT_W'(ZERO_MAX);
  localparam logic [CNT_W-1:0]  O_MIN    = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0]  O_MAX    = CNT_W'(ONE_MAX);
  localparam logic [LO_W-1:0]   GAP_L    = LO_W'(GAP_CYCLES);
  localparam logic [LO_W-1:0]   GAP_M1   = LO_W'(GAP_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

  // Cycles after reset before the sampled line value is trustworthy.
`ifdef ZCD_GLITCH_FILTER_EN
  localparam int PRIME_W = 4;
`else
  localparam int PRIME_W = 2;
`endif

  logic               sync_ff1;
  logic               sync;
  logic               din;
  logic [PRIME_W-1:0] prime;
  logic               primed;
  logic               armed;
  logic               count_en;
  logic [CNT_W-1:0]   hi_cnt;
  logic [LO_W-1:0]    lo_cnt;
  logic               term;
  logic               cls_zero;
  logic               cls_one;
  logic               cls_err;
  logic [SEQ_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;

  // Two-flop synchroniser for the asynchronous zero-crossing input.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      sync_ff1 <= 1'b0;
      sync     <= 1'b0;
    end else begin
      sync_ff1 <= zcd_pulse;
      sync     <= sync_ff1;
    end
  end

`ifdef ZCD_GLITCH_FILTER_EN
  logic [1:0] sync_dly;

  // Keep the two previous synchronised samples for the majority vote.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      sync_dly <= 2'b00;
    end else begin
      sync_dly <= {sync_dly[0], sync};
    end
  end

  assign din = (sync & sync_dly[0]) | (sync & sync_dly[1]) | (sync_dly[0] & sync_dly[1]);
`else
  assign din = sync;
`endif

  // Shift in ones after reset; the top bit marks the sample pipeline as refilled.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      prime <= '0;
    end else begin
      prime <= {prime[PRIME_W-2:0], 1'b1};
    end
  end

  assign primed = prime[PRIME_W-1];

  // Only start measuring once the line has been seen low, so a pulse cut by reset is dropped.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else if (primed && !din) begin
      armed <= 1'b1;
    end
  end

  assign count_en = enable && armed;

  // The symbol closes on the edge where the low run reaches the gap length.
  assign term = count_en && !din && (lo_cnt == GAP_M1) && (hi_cnt != '0);

  // Width windows; a saturated counter is never a legal symbol.
  always_comb begin
    cls_zero = 1'b0;
    cls_one  = 1'b0;
    cls_err  = 1'b0;
    cls_zero = (hi_cnt >= Z_MIN) && (hi_cnt <= Z_MAX);
    cls_one  = (hi_cnt >= O_MIN) && (hi_cnt <= O_MAX);
    cls_err  = (hi_cnt == HI_MAX) || !(cls_zero || cls_one);
  end

  // High/low run counters; short low runs leave the high count untouched.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else if (!count_en) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else if (din) begin
      lo_cnt <= '0;
      if (hi_cnt != HI_MAX) begin
        hi_cnt <= hi_cnt + 1'b1;
      end
    end else begin
      if (lo_cnt != GAP_L) begin
        lo_cnt <= lo_cnt + 1'b1;
      end
      if (term) begin
        hi_cnt <= '0;
      end
    end
  end

  // Registered symbol report; data fields hold their last value between strobes.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      sym_valid <= 1'b0;
      sym_bit   <= 1'b0;
      sym_err   <= 1'b0;
      hi_width  <= '0;
    end else begin
      sym_valid <= term;
      if (term) begin
        sym_bit  <= cls_one && !cls_err;
        sym_err  <= cls_err;
        hi_width <= hi_cnt;
      end
    end
  end

  // Symbol history and error tally; an error symbol breaks any partial pattern.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      hist      <= '0;
      fill      <= '0;
      err_count <= 8'd0;
    end else if (term) begin
      if (cls_err) begin
        hist <= '0;
        fill <= '0;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else begin
        hist <= {hist[SEQ_LEN-2:0], cls_one};
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  // Pattern strobe one cycle after the symbol that completed it.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      seq_detected <= 1'b0;
    end else begin
      seq_detected <= sym_valid && enable && (fill == FILL_MAX) && (hist == SEQ);
    end
  end

endmodule

// File: tb/tb_zcd_pie_decoder.sv
// tb/tb_zcd_pie_decoder.sv - directed and random checks of zcd_pie_decoder against a pulse-level model
module tb_zcd_pie_decoder;

  localparam int GAP = 2;
`ifdef ZCD_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int EXP_LAT = 2 + GAP + (FILT ? 1 : 0);

  logic       sclk_3mhz = 1'b0;
  logic       reset_n;
  logic       zcd_pulse;
  logic       enable;
  logic       sym_valid;
  logic       sym_bit;
  logic       sym_err;
  logic [4:0] hi_width;
  logic       seq_detected;
  logic [7:0] err_count;

  zcd_pie_decoder dut (
    .sclk_3mhz    (sclk_3mhz),
    .reset_n      (reset_n),
    .zcd_pulse    (zcd_pulse),
    .enable       (enable),
    .sym_valid    (sym_valid),
    .sym_bit      (sym_bit),
    .sym_err      (sym_err),
    .hi_width     (hi_width),
    .seq_detected (seq_detected),
    .err_count    (err_count)
  );

  always #5 sclk_3mhz = ~sclk_3mhz;

  int cyc = 0;
  always @(posedge sclk_3mhz) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // observed events
  int obs_w[$];
  int obs_b[$];
  int obs_e[$];
  int obs_seq[$];
  int last_valid_cyc = -1;

  always @(negedge sclk_3mhz) begin
    if (seq_detected === 1'b1) obs_seq.push_back(obs_w.size());
    if (sym_valid === 1'b1) begin
      obs_w.push_back(int'(hi_width));
      obs_b.push_back(int'(sym_bit));
      obs_e.push_back(int'(sym_err));
      last_valid_cyc = cyc;
    end
  end

  // reference model: symbols derived from pulse lengths
  int exp_w[$];
  int exp_b[$];
  int exp_e[$];
  int exp_seq[$];
  int m_hist[$];
  int m_acc = 0;
  int m_err = 0;
  int chk_sym = 0;
  int chk_seq = 0;
  int fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_err = 0;
    m_hist.delete();
  endtask

  task automatic emit(input int w);
    int ws;
    int b;
    int e;
    ws = (w > 31) ? 31 : w;
    if (ws >= 3 && ws <= 6) begin b = 0; e = 0; end
    else if (ws >= 9 && ws <= 12) begin b = 1; e = 0; end
    else begin b = 0; e = 1; end
    exp_w.push_back(ws);
    exp_b.push_back(b);
    exp_e.push_back(e);
    if (e == 1) begin
      m_hist.delete();
      if (m_err < 255) m_err++;
    end else begin
      m_hist.push_back(b);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4 && m_hist[0] == 0 && m_hist[1] == 1 && m_hist[2] == 0 && m_hist[3] == 1)
        exp_seq.push_back(exp_w.size());
    end
  endtask

  task automatic model_pulse(input int hi, input int lo);
    int h;
    h = (FILT && hi == 1) ? 0 : hi;
    m_acc += h;
    if (lo >= GAP) begin
      if (m_acc > 0) emit(m_acc);
      m_acc = 0;
    end else if (FILT && m_acc > 0) begin
      m_acc += lo;
    end
  endtask

  task automatic pulse(input int hi, input int lo, input bit modelled);
    for (int i = 0; i < hi; i++) begin
      @(negedge sclk_3mhz);
      zcd_pulse = 1'b1;
    end
    for (int i = 0; i < lo; i++) begin
      @(negedge sclk_3mhz);
      zcd_pulse = 1'b0;
      if (i == 0) fall_cyc = cyc;
    end
    if (modelled) model_pulse(hi, lo);
  endtask

  task automatic settle();
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk_3mhz);
      zcd_pulse = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge sclk_3mhz);
    reset_n = 1'b0;
    repeat (2) @(negedge sclk_3mhz);
    reset_n = 1'b1;
    repeat (8) @(negedge sclk_3mhz);
    model_reset();
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_nsym", tag), obs_w.size(), exp_w.size());
    for (int i = chk_sym; i < exp_w.size() && i < obs_w.size(); i++) begin
      chk($sformatf("%s_width%0d", tag, i), obs_w[i], exp_w[i]);
      chk($sformatf("%s_bit%0d", tag, i), obs_b[i], exp_b[i]);
      chk($sformatf("%s_err%0d", tag, i), obs_e[i], exp_e[i]);
    end
    chk($sformatf("%s_nseq", tag), obs_seq.size(), exp_seq.size());
    for (int i = chk_seq; i < exp_seq.size() && i < obs_seq.size(); i++)
      chk($sformatf("%s_seqpos%0d", tag, i), obs_seq[i], exp_seq[i]);
    chk($sformatf("%s_err_count", tag), err_count, m_err);
    chk_sym = exp_w.size();
    chk_seq = exp_seq.size();
  endtask

  initial begin
    int hi;
    int lo;
    reset_n   = 1'b0;
    zcd_pulse = 1'b0;
    enable    = 1'b1;
    repeat (3) @(negedge sclk_3mhz);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_bit", sym_bit, 0);
    chk("rst_sym_err", sym_err, 0);
    chk("rst_hi_width", hi_width, 0);
    chk("rst_seq_detected", seq_detected, 0);
    chk("rst_err_count", err_count, 0);
    reset_n = 1'b1;
    repeat (8) @(negedge sclk_3mhz);

    // high 4 -> symbol 0, with latency check
    pulse(4, 3, 1'b1);
    settle();
    check_all("zero4");
    chk("latency", last_valid_cyc - fall_cyc, EXP_LAT);

    // high 10 -> symbol 1
    pulse(10, 3, 1'b1);
    settle();
    check_all("one10");

    // 0,1,0,1,0,1 -> matches after 4th and 6th
    do_reset();
    for (int k = 0; k < 6; k++) pulse((k % 2 == 0) ? 4 : 10, 3, 1'b1);
    settle();
    check_all("seq");

    // error symbol then 1,0,1
    pulse(7, 3, 1'b1);
    settle();
    check_all("err7");
    pulse(10, 3, 1'b1);
    pulse(4, 3, 1'b1);
    pulse(10, 3, 1'b1);
    settle();
    check_all("after_err");

    // bridged low run and saturation
    pulse(3, 1, 1'b1);
    pulse(3, 2, 1'b1);
    settle();
    check_all("bridge");
    pulse(40, 3, 1'b1);
    settle();
    check_all("sat");

    // reset during the 5th high cycle discards the pulse
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk_3mhz);
      zcd_pulse = 1'b1;
    end
    @(negedge sclk_3mhz);
    reset_n = 1'b0;
    @(negedge sclk_3mhz);
    reset_n = 1'b1;
    repeat (3) @(negedge sclk_3mhz);
    @(negedge sclk_3mhz);
    zcd_pulse = 1'b0;
    settle();
    model_reset();
    check_all("rst_mid");
    chk("rst_mid_sym_bit", sym_bit, 0);
    chk("rst_mid_sym_err", sym_err, 0);
    chk("rst_mid_hi_width", hi_width, 0);
    chk("rst_mid_seq_detected", seq_detected, 0);
    pulse(4, 3, 1'b1);
    settle();
    check_all("post_rst");

    // single-cycle high
    pulse(1, 3, 1'b1);
    settle();
    check_all("glitch");

    // decoding disabled
    enable = 1'b0;
    pulse(4, 3, 1'b0);
    settle();
    enable = 1'b1;
    settle();
    check_all("disabled");

    // random pulse train
    for (int n = 0; n < 40; n++) begin
      hi = ($urandom_range(0, 7) == 0) ? 35 : int'($urandom_range(2, 14));
      lo = (n == 39) ? 5 : int'($urandom_range(1, 5));
      pulse(hi, lo, 1'b1);
    end
    settle();
    check_all("rnd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zcd_pie_decoder.md
ZCD_PIE_DECODER -- requirements
Module: zcd_pie_decoder

Interface
REQ-001 Parameter CNT_W, 5: width of high/low pulse counters.
REQ-002 Parameter ZERO_MIN, 3: min high width (cycles) classified as symbol 0.
REQ-003 Parameter ZERO_MAX, 6: max high width classified as symbol 0.
REQ-004 Parameter ONE_MIN, 9: min high width classified as symbol 1.
REQ-005 Parameter ONE_MAX, 12: max high width classified as symbol 1.
REQ-006 Parameter GAP_CYCLES, 2: consecutive low cycles that terminate a symbol.
REQ-007 Parameter SEQ_LEN, 4: length of the matched symbol pattern.
REQ-008 Parameter SEQ, 4'b0101: pattern, MSB is oldest symbol.
REQ-009 sclk_3mhz  in  1  sole clock, all logic on rising edge.
REQ-010 reset_n  in  1  synchronous, active-low reset.
REQ-011 zcd_pulse  in  1  asynchronous zero-crossing pulse.
REQ-012 enable  in  1  decode enable.
REQ-013 sym_valid  out  1  one-cycle strobe per terminated symbol.
REQ-014 sym_bit  out  1  decoded symbol, qualified by sym_valid.
REQ-015 sym_err  out  1  symbol width in neither window, qualified by sym_valid.
REQ-016 hi_width  out  CNT_W  measured high width, qualified by sym_valid.
REQ-017 seq_detected  out  1  one-cycle strobe on pattern match.
REQ-018 err_count  out  8  saturating count of error symbols.

Function
REQ-019 zcd_pulse SHALL pass a 2-flop synchroniser; all decoding uses the synchronised value (sync).
REQ-020 Hi counter SHALL increment each cycle sync=1, saturating at 2^CNT_W-1; low cycles are not counted.
REQ-021 Lo counter SHALL increment each cycle sync=0, saturating at GAP_CYCLES, and clear when sync=1.
REQ-022 Low runs shorter than GAP_CYCLES SHALL be bridged: hi counter keeps its value and resumes counting.
REQ-023 When lo counter reaches GAP_CYCLES with hi counter nonzero, next edge SHALL register sym_valid=1, hi_width=hi counter, and clear hi counter.
REQ-024 Classification: ZERO_MIN..ZERO_MAX -> sym_bit=0,sym_err=0; ONE_MIN..ONE_MAX -> sym_bit=1,sym_err=0; otherwise sym_bit=0,sym_err=1; saturated width is an error.
REQ-025 Latency from zcd_pulse falling edge to sym_valid SHALL be 2+GAP_CYCLES cycles (±1 for asynchronous sampling).
REQ-026 No sym_valid SHALL occur while sync stays low with hi counter zero.
REQ-027 Valid non-error symbol SHALL shift into SEQ_LEN-bit history and increment a fill counter saturating at SEQ_LEN.
REQ-028 seq_detected SHALL pulse the cycle after sym_valid when fill=SEQ_LEN and history==SEQ; overlapping matches SHALL be detected.
REQ-029 Error symbol SHALL clear history and fill counter, and increment err_count, saturating at 255.
REQ-030 enable=0 SHALL hold hi/lo counters at zero and suppress sym_valid/seq_detected; synchroniser, history, err_count retained.
REQ-031 Outputs sym_valid, sym_bit, sym_err, hi_width, seq_detected SHALL be registered.

Reset
REQ-032 reset_n=0 at a rising edge SHALL clear synchroniser, counters, history, fill, err_count and all outputs to 0.
REQ-033 Reset mid-symbol SHALL discard the partial symbol; no sym_valid for it after release.

Configuration
REQ-034 Macro ZCD_GLITCH_FILTER_EN defined: 3-sample majority filter after synchroniser, +1 cycle latency, single-cycle high or low glitches removed.
REQ-035 ZCD_GLITCH_FILTER_EN undefined: no filter, latency per REQ-025, single-cycle highs counted as width 1.

Verification
REQ-036 High 4, low 3 -> sym_valid once, sym_bit=0, sym_err=0, hi_width=4.
REQ-037 High 10, low 3 -> sym_bit=1, hi_width=10.
REQ-038 Symbols 0,1,0,1,0,1 -> seq_detected after 4th and 6th symbols only.
REQ-039 High 7 then symbols 1,0,1 -> sym_err=1, err_count=1, no seq_detected (history cleared).
REQ-040 High 3, low 1, high 3, low 2 -> single symbol, hi_width=6, sym_bit=0; high 40 -> hi_width=31, sym_err=1.
REQ-041 reset_n low 1 cycle during 5th high cycle -> no sym_valid for that pulse; all outputs 0; next high 4 decodes as 0.
